// File: rtl/div64_seq.sv
// 64-by-32 unsigned restoring divider producing a 64-bit quotient and a 32-bit remainder.
// Latency: done 65 cycles after the accepting edge, or 1 cycle when the divisor is zero.
// Backpressure: a single operation is in flight at a time, and start is ignored while busy or done.
module div64_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [63:0] dividend,
    input  logic [31:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [63:0] quotient,
    output logic [31:0] remainder,
    output logic        div_by_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [63:0] q_sh;      // dividend shifting out the top, quotient bits entering at the bottom
    logic [31:0] d_reg;     // latched divisor
    logic [31:0] r_reg;     // partial remainder; its 33rd bit is always zero between steps
    logic [5:0]  cnt;       // steps remaining after the current one

    logic [32:0] trial;
    logic        fits;
    logic [31:0] r_step;
    logic [63:0] q_step;

    // One restoring step: shift the next dividend bit into the remainder, then subtract if it fits
    always_comb begin
        trial  = {r_reg, q_sh[63]};
        fits   = (trial >= {1'b0, d_reg});
        r_step = fits ? 32'(trial - {1'b0, d_reg}) : trial[31:0];
        q_step = {q_sh[62:0], fits};
    end

    // Next-state logic: a zero divisor skips straight to DONE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (divisor == 32'd0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (cnt == 6'd0) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Handshake outputs decode the registered state, so they can never both be high
    assign busy = (state == RUN);
    assign done = (state == DONE);

    // Datapath: load on accept, step while running, publish results on the edge into DONE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_sh        <= 64'd0;
            d_reg       <= 32'd0;
            r_reg       <= 32'd0;
            cnt         <= 6'd0;
            quotient    <= 64'd0;
            remainder   <= 32'd0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        q_sh  <= dividend;
                        d_reg <= divisor;
                        r_reg <= 32'd0;
                        cnt   <= 6'd63;
                        if (divisor == 32'd0) begin
                            quotient    <= {64{1'b1}};
                            remainder   <= dividend[31:0];
                            div_by_zero <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    q_sh  <= q_step;
                    r_reg <= r_step;
                    cnt   <= cnt - 6'd1;
                    if (cnt == 6'd0) begin
                        quotient    <= q_step;
                        remainder   <= r_step;
                        div_by_zero <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
